uart_rx: RTL and testbench

UART receiver that consumes the single-cycle oversample tick from the baud generator and de-serialises an asynchronous rx line into parallel bytes. The tick rate is 16x the bit rate, set by the generator's divisor. Each received word is presented on a one-entry holding register with a valid/ready handshake toward the host-side logic or FIFO. Framing errors and overruns are flagged.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types and constants: receiver FSM encoding, default
//           oversample ratio and idle line level.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int   OS_DEFAULT = 16;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module  : uart_rx_sync
// Brief   : Two-flop synchroniser for an asynchronous input with a
//           parameterised reset level (rx, cts and similar lines).
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync
    import uart_pkg::*;
#(
    parameter logic RST_VAL = IDLE_LEVEL
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : Oversampling UART receiver with a one-entry valid/ready holding
//           register, framing-error, overrun and optional parity checking
//           (parity stage compiled in by defining UART_RX_PARITY_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OS_DEFAULT,
    parameter int SB_TICKS   = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int S_W = $clog2(SB_TICKS);
    localparam int N_W = $clog2(DATA_BITS);

    localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [S_W-1:0]       s_q;
    logic [N_W-1:0]       n_q;
    logic [DATA_BITS-1:0] sr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 busy_q;
    logic                 brk_q;
`ifdef UART_RX_PARITY_EN
    logic                 pbit_q;
    logic                 perr_q;
`endif

    uart_rx_sync #(
        .RST_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (rx),
        .sync_o  (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
            brk_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            ovr_q <= 1'b0;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    // After a line break, hold off until the line returns high.
                    if (rx_s) begin
                        brk_q <= 1'b0;
                    end else if (!brk_q) begin
                        state_q <= ST_START;
                        s_q     <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                ST_START: if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                            s_q     <= '0;
                            n_q     <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end

                ST_DATA: if (s_tick) begin
                    if (s_q == S_LAST) begin
                        sr_q <= {rx_s, sr_q[DATA_BITS-1:1]};
                        s_q  <= '0;
                        n_q  <= n_q + N_W'(1);
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: if (s_tick) begin
                    if (s_q == S_LAST) begin
                        pbit_q  <= rx_s;
                        s_q     <= '0;
                        state_q <= ST_STOP;
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end
`endif

                ST_STOP: if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        brk_q   <= ~rx_s;
                        // A word still pending and not taken this clk wins over the new one.
                        if (!valid_q || rx_ready) begin
                            data_q  <= sr_q;
                            ferr_q  <= ~rx_s;
                            valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q  <= (^sr_q) ^ pbit_q ^ PARITY_ODD;
`endif
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end else begin
                        s_q <= s_q + S_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = PARITY_ODD & 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Directed self-checking bench for uart_rx (8N1, tick every 4 clk).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int         n_vec = 0;
    int         n_err = 0;
    int         valid_cycles = 0;
    int         ovr_cnt = 0;
    logic [9:0] got_q[$];
    int         tcnt = 0;

    uart_rx u_dut (
        .clk        (clk),
        .rst        (rst),
        .s_tick     (s_tick),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcnt   <= (tcnt + 1) % 4;
        s_tick <= (tcnt == 3);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) got_q.push_back({frame_err, parity_err, rx_data});
            if (overrun) ovr_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                              input bit has_par, input logic par);
        rx = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BIT_CLK);
        end
        if (has_par) begin
            rx = par;
            idle(BIT_CLK);
        end
        rx = stop_lvl;
        idle(BIT_CLK);
        rx = 1'b1;
    endtask

    task automatic expect_word(input string tag, input logic [7:0] d,
                               input logic fe, input logic pe);
        logic [9:0] w;
        check_eq({tag, " present"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0) begin
            w = got_q.pop_front();
            check_eq({tag, " data"}, 32'(w[7:0]), 32'(d));
            check_eq({tag, " frame_err"}, 32'(w[9]), 32'(fe));
            check_eq({tag, " parity_err"}, 32'(w[8]), 32'(pe));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        idle(3);
        settle();
        check_eq("rst rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst rx_data", 32'(rx_data), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst frame_err", 32'(frame_err), 32'd0);
        check_eq("rst parity_err", 32'(parity_err), 32'd0);
        check_eq("rst overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(20);

        // Clean frame
        settle();
        valid_cycles = 0;
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        idle(40);
        settle();
        expect_word("t1", 8'h55, 1'b0, 1'b0);
        check_eq("t1 valid width", 32'(valid_cycles), 32'd1);
        check_eq("t1 busy", 32'(busy), 32'd0);

        // Back-to-back
        ovr_cnt = 0;
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        idle(40);
        settle();
        expect_word("t2a", 8'hA3, 1'b0, 1'b0);
        expect_word("t2b", 8'h0F, 1'b0, 1'b0);
        check_eq("t2 overrun", 32'(ovr_cnt), 32'd0);

        // False start: 3 ticks low
        rx = 1'b0;
        idle(8);
        settle();
        check_eq("t3 busy during glitch", 32'(busy), 32'd1);
        idle(3);
        rx = 1'b1;
        idle(150);
        settle();
        check_eq("t3 no word", 32'(got_q.size()), 32'd0);
        check_eq("t3 busy", 32'(busy), 32'd0);

        // Framing error, then clean frame
        send_frame(8'hC6, 1'b0, 1'b0, 1'b0);
        idle(BIT_CLK);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        idle(40);
        settle();
        expect_word("t4 ferr", 8'hC6, 1'b1, 1'b0);
        expect_word("t4 clean", 8'h12, 1'b0, 1'b0);

        // Overrun
        @(posedge clk); #1 rx_ready = 1'b0;
        ovr_cnt = 0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        idle(40);
        settle();
        check_eq("t5 valid held", 32'(rx_valid), 32'd1);
        check_eq("t5 data held", 32'(rx_data), 32'h11);
        check_eq("t5 overrun pulses", 32'(ovr_cnt), 32'd1);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk);
        settle();
        check_eq("t5 valid drop", 32'(rx_valid), 32'd0);
        expect_word("t5 accept", 8'h11, 1'b0, 1'b0);
        check_eq("t5 queue empty", 32'(got_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle(40);
        settle();
        expect_word("t6 par ok", 8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(40);
        settle();
        expect_word("t6 par bad", 8'h07, 1'b0, 1'b1);
`endif

        // Reset mid-frame with a word pending
        @(posedge clk); #1 rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(40);
        settle();
        check_eq("t7 pending valid", 32'(rx_valid), 32'd1);
        check_eq("t7 pending data", 32'(rx_data), 32'h5A);
        rx = 1'b0;
        idle(4 * BIT_CLK);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check_eq("t7 rst rx_valid", 32'(rx_valid), 32'd0);
        check_eq("t7 rst rx_data", 32'(rx_data), 32'd0);
        check_eq("t7 rst busy", 32'(busy), 32'd0);
        check_eq("t7 rst frame_err", 32'(frame_err), 32'd0);
        rx = 1'b1;
        idle(3);
        @(posedge clk); #1 rst = 1'b0;
        rx_ready = 1'b1;
        idle(300);
        settle();
        check_eq("t7 no word", 32'(got_q.size()), 32'd0);
        check_eq("t7 busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
